// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, default datapath widths,
// reset PC and the fetch FSM state encoding.
package cpu_pkg;

  // Default datapath widths for the fetch/decode slice
  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 8;

  // PC loaded on reset
  localparam logic [7:0] RESET_PC_DEF = 8'h00;

  // Opcode field occupies instr[INSTR_W-1 -: 2]
  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_J   = 2'b11;

  // Fetch FSM: FETCH = nothing outstanding, WAIT = one good request
  // outstanding, DRAIN = outstanding request belongs to the wrong path
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_WAIT  = 2'b01,
    ST_DRAIN = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer: DEPTH entries of WIDTH bits, registered storage,
// combinational head. Flush empties it in one cycle and wins over push/pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full  = (count_r == CNT_MAX);
  assign empty = (count_r == {CNT_W{1'b0}});
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Guard against overflow/underflow so the pointers can never skew
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Storage write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit_chk.sv
// Invariant checker for fetch_unit: the buffer is never pushed while full
// (at most one request is ever outstanding) and the FSM never holds an
// unused encoding.
module fetch_unit_chk (
  input logic       clk,
  input logic       reset,
  input logic       push,
  input logic       full,
  input logic [1:0] state
);

  a_no_push_when_full : assert property (@(posedge clk) disable iff (reset)
    !(push && full));

  a_legal_state : assert property (@(posedge clk) disable iff (reset)
    state != 2'b11);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues single-outstanding word reads
// to a variable-latency instruction memory, buffers responses and hands them
// to decode over valid/ready. A redirect flushes all wrong-path work; a
// request already in flight is drained and its response dropped.
// Optional build macro FETCH_PERF_EN adds saturating stall/flush counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_stall_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  localparam int ENT_W = INSTR_W + ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1'b1);

  fetch_state_t           state_r;
  fetch_state_t           state_nxt_s;
  logic [ADDR_W-1:0]      pc_r;
  logic [ADDR_W-1:0]      pc_nxt_s;
  logic [ADDR_W-1:0]      issued_pc_r;

  logic                   req_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [$clog2(DEPTH):0] fifo_count_s;
  logic [ENT_W-1:0]       fifo_head_s;
  logic [ENT_W-1:0]       fifo_din_s;

  // Handshake decode: request, accept of a good response, and head pop.
  // Redirect suppresses all three so nothing wrong-path is issued or kept.
  always_comb begin
    req_s      = !reset && (state_r == ST_FETCH) && !fifo_full_s && !redirect;
    push_s     = (state_r == ST_WAIT) && imem_rvalid && !redirect;
    pop_s      = !fifo_empty_s && instr_ready && !redirect;
    fifo_din_s = {imem_rdata, issued_pc_r};
  end

  // Next-state and next-PC logic
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      ST_FETCH: begin
        if (redirect) begin
          state_nxt_s = ST_FETCH;
        end else if (req_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        // A response retires the request whether or not it is kept;
        // a redirect without a response leaves a wrong-path request in flight
        if (imem_rvalid) begin
          state_nxt_s = ST_FETCH;
        end else if (redirect) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        // The wrong-path response is dropped; a same-cycle redirect only
        // moves the PC since nothing remains outstanding afterwards
        if (imem_rvalid) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_FETCH;
      end
    endcase

    if (redirect) begin
      pc_nxt_s = redirect_pc;
    end else if (req_s) begin
      pc_nxt_s = pc_r + PC_ONE;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // FSM state and PC registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Remember the PC of the outstanding request to tag its response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_pc_r <= RESET_PC;
    end else if (req_s) begin
      issued_pc_r <= pc_r;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect),
    .din   (fifo_din_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

  fetch_unit_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .full  (fifo_full_s),
    .state (state_r)
  );

  // Output mapping; head fields read as zero while the buffer is empty
  always_comb begin
    imem_req    = req_s;
    imem_addr   = pc_r;
    instr_valid = !fifo_empty_s;
    if (!fifo_empty_s) begin
      instr    = fifo_head_s[ADDR_W +: INSTR_W];
      instr_pc = fifo_head_s[ADDR_W-1:0];
    end else begin
      instr    = {INSTR_W{1'b0}};
      instr_pc = {ADDR_W{1'b0}};
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_r;
  logic [15:0] perf_flush_r;

  // Saturating counters: decode back-pressure cycles and redirect cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_r <= 16'h0000;
      perf_flush_r <= 16'h0000;
    end else begin
      if (!fifo_empty_s && !instr_ready && (perf_stall_r != 16'hFFFF)) begin
        perf_stall_r <= perf_stall_r + 16'h0001;
      end
      if (redirect && (perf_flush_r != 16'hFFFF)) begin
        perf_flush_r <= perf_flush_r + 16'h0001;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_r;
  assign perf_flush_cnt = perf_flush_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural variable-latency memory.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_rvalid;
  logic [7:0] imem_rdata;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       redirect;
  logic [7:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // memory model state
  int         lat = 1;
  int         cd  = 0;
  logic [7:0] pend = 8'h00;

  // per-cycle samples
  logic       s_req, s_valid;
  logic [7:0] s_addr, s_instr, s_pc;

  typedef struct {
    logic       exp_req;
    logic [7:0] exp_addr;
    logic       exp_valid;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs and memory response after the falling
  // edge, sample outputs, then let the memory capture any request.
  task automatic cycle(input logic rdy, input logic rd, input logic [7:0] rpc);
    @(negedge clk);
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rvalid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_f(pend);
      end
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_instr = instr;
    s_pc    = instr_pc;
    if (s_req) begin
      pend = s_addr;
      cd   = lat;
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    imem_rvalid = 1'b0;
    imem_rdata  = 8'h00;
    cd          = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 8'h00);
    chk("rst_pc", instr_pc, 8'h00);
`ifdef FETCH_PERF_EN
    chk("rst_perf_stall", perf_stall_cnt, 16'h0000);
    chk("rst_perf_flush", perf_flush_cnt, 16'h0000);
`endif
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  nreq;
    bit  found;

    // ---------- sequential fetch, latency 1, always ready ----------
    vecs[0] = '{1'b1, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'h01, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 8'h02, 1'b1, 8'h01};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 8'h03, 1'b1, 8'h02};

    lat = 1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      chk($sformatf("seq_req[%0d]", i), s_req, vecs[i].exp_req);
      if (vecs[i].exp_req) chk($sformatf("seq_addr[%0d]", i), s_addr, vecs[i].exp_addr);
      chk($sformatf("seq_valid[%0d]", i), s_valid, vecs[i].exp_valid);
      chk($sformatf("seq_pc[%0d]", i), s_pc, vecs[i].exp_pc);
      chk($sformatf("seq_instr[%0d]", i), s_instr,
          vecs[i].exp_valid ? mem_f(vecs[i].exp_pc) : 8'h00);
    end

    // ---------- back-pressure: buffer fills, requests stop ----------
    do_reset();
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (s_req) begin
        chk("bp_req_addr", s_addr, 8'(nreq));
        nreq++;
      end
    end
    chk("bp_req_count", 16'(nreq), 16'd2);
    chk("bp_full_valid", s_valid, 1'b1);
    chk("bp_full_pc", s_pc, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    chk("bp_drain0_pc", s_pc, 8'h00);
    chk("bp_drain0_noreq", s_req, 1'b0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("bp_drain1_pc", s_pc, 8'h01);
    chk("bp_drain1_valid", s_valid, 1'b1);
    chk("bp_resume_req", s_req, 1'b1);
    chk("bp_resume_addr", s_addr, 8'h02);
    cycle(1'b1, 1'b0, 8'h00);
    chk("bp_gap_valid", s_valid, 1'b0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("bp_pc2", s_pc, 8'h02);
    chk("bp_instr2", s_instr, mem_f(8'h02));

    // ---------- redirect while a request is outstanding ----------
    lat = 3;
    do_reset();
    cycle(1'b1, 1'b0, 8'h00);
    chk("rw_first_req", s_req, 1'b1);
    cycle(1'b1, 1'b1, 8'h40);
    chk("rw_redirect_noreq", s_req, 1'b0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("rw_drain_noreq", s_req, 1'b0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("rw_drop_rvalid", imem_rvalid, 1'b1);
    chk("rw_drop_noreq", s_req, 1'b0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("rw_dropped_valid", s_valid, 1'b0);
    chk("rw_target_req", s_req, 1'b1);
    chk("rw_target_addr", s_addr, 8'h40);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      if (s_valid) begin
        found = 1'b1;
        chk("rw_first_valid_pc", s_pc, 8'h40);
        chk("rw_first_valid_instr", s_instr, mem_f(8'h40));
      end
    end
    if (!found) chk("rw_valid_timeout", 1'b0, 1'b1);

    // ---------- redirect coincident with rvalid and a pop ----------
    lat = 1;
    do_reset();
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    chk("co_pre_valid", s_valid, 1'b1);
    cycle(1'b1, 1'b1, 8'h80);
    chk("co_rvalid_same", imem_rvalid, 1'b1);
    chk("co_redirect_noreq", s_req, 1'b0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("co_flushed_valid", s_valid, 1'b0);
    chk("co_target_req", s_req, 1'b1);
    chk("co_target_addr", s_addr, 8'h80);
    cycle(1'b1, 1'b0, 8'h00);
    chk("co_wait_valid", s_valid, 1'b0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("co_new_pc", s_pc, 8'h80);

    // ---------- PC wrap 0xFF -> 0x00; best-case redirect latency ----------
    do_reset();
    cycle(1'b1, 1'b1, 8'hFF);
    chk("wr_redirect_noreq", s_req, 1'b0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("wr_addr_ff", s_addr, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    chk("wr_valid_3cyc", s_valid, 1'b1);
    chk("wr_pc_ff", s_pc, 8'hFF);
    chk("wr_addr_00", s_addr, 8'h00);

    // ---------- stalls, redirects, then asynchronous reset ----------
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h10);
    cycle(1'b1, 1'b1, 8'h20);
    cycle(1'b1, 1'b0, 8'h00);
    chk("pf_addr_20", s_addr, 8'h20);
`ifdef FETCH_PERF_EN
    chk("pf_stall_cnt", perf_stall_cnt, 16'd5);
    chk("pf_flush_cnt", perf_flush_cnt, 16'd2);
`endif
    #1 reset = 1'b1;
    #1;
    cd = 0;
    chk("ar_addr", imem_addr, 8'h00);
    chk("ar_req", imem_req, 1'b0);
    chk("ar_valid", instr_valid, 1'b0);
`ifdef FETCH_PERF_EN
    chk("ar_perf_stall", perf_stall_cnt, 16'h0000);
    chk("ar_perf_flush", perf_flush_cnt, 16'h0000);
`endif
    do_reset();
    cycle(1'b1, 1'b0, 8'h00);
    chk("ar_restart_addr", s_addr, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
